// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the keyboard-driven stopwatch engine:
// FSM state encoding, default scancodes, key indices and the digit bundle.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [8:0] SPACE_CODE_DEF = 9'h029;
  localparam logic [8:0] ENTER_CODE_DEF = 9'h05A;
  localparam logic [8:0] ESC_CODE_DEF   = 9'h076;

  localparam int KEY_SPACE = 0;
  localparam int KEY_ENTER = 1;
  localparam int KEY_ESC   = 2;

  // Full display value, most significant digit first; hr stays 0 without hours.
  typedef struct packed {
    logic [DIGIT_W-1:0] hr;
    logic [DIGIT_W-1:0] min10;
    logic [DIGIT_W-1:0] min1;
    logic [DIGIT_W-1:0] sec10;
    logic [DIGIT_W-1:0] sec1;
    logic [DIGIT_W-1:0] cs10;
    logic [DIGIT_W-1:0] cs1;
  } digits_t;

endpackage

// File: rtl/stopwatch_core_digit.sv
// Single BCD digit counter (0..MAX) with synchronous clear and ripple carry-out.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] r_q;

  assign carry = inc & (r_q == MAX);
  assign q     = r_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == MAX) ? '0 : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: PS/2 key decode, IDLE/RUN/PAUSE FSM, MM:SS.cc counter, lap freeze.
// Optional hours digit when STOPWATCH_HOURS_EN is defined.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         TICK_HZ    = 100,
  parameter logic [8:0] SPACE_CODE = SPACE_CODE_DEF,
  parameter logic [8:0] ENTER_CODE = ENTER_CODE_DEF,
  parameter logic [8:0] ESC_CODE   = ESC_CODE_DEF
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [8:0] scancode,
  input  logic       Released,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] cs_10s,
  output logic [3:0] cs_1s,
  output logic [3:0] hr_1s,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int            DIV     = CLK_HZ / TICK_HZ;
  localparam int            PW      = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [8:0]    r_code_s1, r_code_s2;
  logic          r_rel_s1, r_rel_s2;
  logic [2:0]    w_hit, r_hit, r_hit_d, w_press;
  state_t        r_state, w_state_nxt;
  logic          r_running, r_lap_active, r_wrap;
  logic          w_clr, w_lap_nxt, w_capture, w_tick;
  logic [PW-1:0] r_pre;
  digits_t       r_lap, w_live, w_disp;

  logic w_inc_cs1, w_inc_cs10, w_inc_sec1, w_inc_sec10, w_inc_min1, w_inc_min10;
  logic w_carry_cs1, w_carry_cs10, w_carry_sec1, w_carry_sec10, w_carry_min1, w_carry_min10;
  logic w_carry_top;
  logic [3:0] w_q_hr, w_q_min10, w_q_min1, w_q_sec10, w_q_sec1, w_q_cs10, w_q_cs1;

  // Two-flop synchroniser, then a registered hit stage feeding the edge detector.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_code_s1 <= '0;
      r_code_s2 <= '0;
      r_rel_s1  <= 1'b0;
      r_rel_s2  <= 1'b0;
      r_hit     <= '0;
      r_hit_d   <= '0;
    end else begin
      r_code_s1 <= scancode;
      r_code_s2 <= r_code_s1;
      r_rel_s1  <= Released;
      r_rel_s2  <= r_rel_s1;
      r_hit     <= w_hit;
      r_hit_d   <= r_hit;
    end
  end

  assign w_hit   = {r_code_s2 == ESC_CODE, r_code_s2 == ENTER_CODE, r_code_s2 == SPACE_CODE}
                 & {3{~r_rel_s2}};
  assign w_press = r_hit & ~r_hit_d;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
    end
  end

  // ESC outranks ENTER, which outranks SPACE.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_lap_nxt   = r_lap_active;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press[KEY_ESC]) begin
          w_clr = 1'b1;
        end else if (w_press[KEY_SPACE] && !w_press[KEY_ENTER]) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_press[KEY_ESC]) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end else if (w_press[KEY_ENTER]) begin
          w_lap_nxt = ~r_lap_active;
          w_capture = ~r_lap_active;
        end else if (w_press[KEY_SPACE]) begin
          w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (w_press[KEY_ESC]) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end else if (w_press[KEY_ENTER]) begin
          if (r_lap_active) begin
            w_lap_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
            w_clr       = 1'b1;
          end
        end else if (w_press[KEY_SPACE]) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
      end
    endcase
    if (w_clr) w_lap_nxt = 1'b0;
  end

  assign w_tick = (r_state == RUN) && (r_pre == PRE_MAX);

  // Clear outranks a coincident tick; lap capture sees the pre-tick digits.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_pre        <= '0;
      r_lap_active <= 1'b0;
      r_lap        <= '0;
      r_wrap       <= 1'b0;
    end else begin
      if (w_clr) begin
        r_pre <= '0;
      end else if (r_state == RUN) begin
        r_pre <= (r_pre == PRE_MAX) ? '0 : r_pre + PW'(1);
      end
      r_lap_active <= w_lap_nxt;
      if (w_clr) begin
        r_lap <= '0;
      end else if (w_capture) begin
        r_lap <= w_live;
      end
      r_wrap <= w_carry_top & ~w_clr;
    end
  end

  assign w_inc_cs1   = w_tick;
  assign w_inc_cs10  = w_carry_cs1;
  assign w_inc_sec1  = w_carry_cs10;
  assign w_inc_sec10 = w_carry_sec1;
  assign w_inc_min1  = w_carry_sec10;
  assign w_inc_min10 = w_carry_min1;

  bcd_digit_cnt #(.MAX(4'd9)) u_cs1 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_cs1),
    .q(w_q_cs1), .carry(w_carry_cs1));
  bcd_digit_cnt #(.MAX(4'd9)) u_cs10 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_cs10),
    .q(w_q_cs10), .carry(w_carry_cs10));
  bcd_digit_cnt #(.MAX(4'd9)) u_sec1 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_sec1),
    .q(w_q_sec1), .carry(w_carry_sec1));
  bcd_digit_cnt #(.MAX(4'd5)) u_sec10 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_sec10),
    .q(w_q_sec10), .carry(w_carry_sec10));
  bcd_digit_cnt #(.MAX(4'd9)) u_min1 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_min1),
    .q(w_q_min1), .carry(w_carry_min1));
  bcd_digit_cnt #(.MAX(4'd5)) u_min10 (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_min10),
    .q(w_q_min10), .carry(w_carry_min10));

`ifdef STOPWATCH_HOURS_EN
  logic w_inc_hr;
  assign w_inc_hr = w_carry_min10;
  bcd_digit_cnt #(.MAX(4'd9)) u_hr (
    .clk(clk_100MHz), .reset(reset), .clr(w_clr), .inc(w_inc_hr),
    .q(w_q_hr), .carry(w_carry_top));
`else
  assign w_q_hr      = 4'd0;
  assign w_carry_top = w_carry_min10;
`endif

  assign w_live = {w_q_hr, w_q_min10, w_q_min1, w_q_sec10, w_q_sec1, w_q_cs10, w_q_cs1};
  assign w_disp = r_lap_active ? r_lap : w_live;

  assign hr_1s      = w_disp.hr;
  assign min_10s    = w_disp.min10;
  assign min_1s     = w_disp.min1;
  assign sec_10s    = w_disp.sec10;
  assign sec_1s     = w_disp.sec1;
  assign cs_10s     = w_disp.cs10;
  assign cs_1s      = w_disp.cs1;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed, scoreboard-checked bench for stopwatch_core at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic [8:0] scancode;
  logic       Released;
  logic [3:0] min_10s, min_1s, sec_10s, sec_1s, cs_10s, cs_1s, hr_1s;
  logic       running, lap_active, wrap;

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .scancode(scancode), .Released(Released),
    .min_10s(min_10s), .min_1s(min_1s), .sec_10s(sec_10s), .sec_1s(sec_1s),
    .cs_10s(cs_10s), .cs_1s(cs_1s), .hr_1s(hr_1s),
    .running(running), .lap_active(lap_active), .wrap(wrap));

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] disp();
    return {4'h0, hr_1s, min_10s, min_1s, sec_10s, sec_1s, cs_10s, cs_1s};
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0h, no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  // Key make; returns at the negedge after the edge where its effect lands.
  task automatic press(input logic [8:0] code);
    scancode = code;
    Released = 1'b0;
    cyc(4);
  endtask

  // Key break; long enough for the edge detector to re-arm.
  task automatic rel();
    Released = 1'b1;
    cyc(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    scancode = '0;
    Released = 1'b1;
    cyc(3);
    push("rst_digits", 32'h0);  check(disp());
    push("rst_running", 32'h0); check(32'(running));
    push("rst_lap", 32'h0);     check(32'(lap_active));
    push("rst_wrap", 32'h0);    check(32'(wrap));
    reset = 1'b0;
    cyc(2);

    // Start latency, first tick, one second.
    scancode = SPACE_CODE_DEF;
    Released = 1'b0;
    push("t1_lat3_running", 32'h0);    cyc(3);   check(32'(running));
    push("t1_lat4_running", 32'h1);    cyc(1);   check(32'(running));
    push("t1_pre9_digits", 32'h0);     cyc(9);   check(disp());
    push("t1_first_tick", 32'h1);      cyc(1);   check(disp());
    push("t1_one_second", 32'h100);    cyc(990); check(disp());

    // Clear, run 37 ticks, pause mid-prescale, resume.
    rel();
    push("t2_esc_digits", 32'h0);
    push("t2_esc_running", 32'h0);
    press(ESC_CODE_DEF);
    check(disp());
    check(32'(running));
    rel();
    press(SPACE_CODE_DEF);
    rel();
    cyc(367);
    push("t2_pause_digits", 32'h37);
    push("t2_pause_running", 32'h0);
    press(SPACE_CODE_DEF);
    check(disp());
    check(32'(running));
    push("t2_pause_hold", 32'h37);     cyc(500); check(disp());
    rel();
    push("t2_resume_running", 32'h1);
    press(SPACE_CODE_DEF);
    check(32'(running));
    push("t2_resume_pre_tick", 32'h37); cyc(4); check(disp());
    push("t2_resume_tick", 32'h38);     cyc(1); check(disp());

    // Lap capture on a tick edge freezes the pre-tick value.
    rel();
    cyc(822);
    push("t3_lap_on", 32'h1);
    push("t3_lap_value", 32'h120);
    press(ENTER_CODE_DEF);
    check(32'(lap_active));
    check(disp());
    push("t3_lap_frozen", 32'h120);    cyc(100); check(disp());
    rel();
    push("t3_lap_off", 32'h0);
    push("t3_live_value", 32'h131);
    press(ENTER_CODE_DEF);
    check(32'(lap_active));
    check(disp());

    // Rollover at 59:59.99.
    rel();
    push("t4_clear", 32'h0);
    press(ESC_CODE_DEF);
    check(disp());
    rel();
    force dut.w_inc_cs1 = 1'b1;   cyc(8); release dut.w_inc_cs1;
    force dut.w_inc_cs10 = 1'b1;  cyc(9); release dut.w_inc_cs10;
    force dut.w_inc_sec1 = 1'b1;  cyc(9); release dut.w_inc_sec1;
    force dut.w_inc_sec10 = 1'b1; cyc(5); release dut.w_inc_sec10;
    force dut.w_inc_min1 = 1'b1;  cyc(9); release dut.w_inc_min1;
    force dut.w_inc_min10 = 1'b1; cyc(5); release dut.w_inc_min10;
    push("t4_preload", 32'h0595998);   check(disp());
    press(SPACE_CODE_DEF);
    push("t4_last_digits", 32'h0595999);
    push("t4_last_wrap", 32'h0);
    cyc(10);
    check(disp());
    check(32'(wrap));
    push("t4_wrap_before", 32'h0);     cyc(9); check(32'(wrap));
    push("t4_rollover", 32'h0);
    push("t4_wrap_pulse", 32'h1);
    cyc(1);
    check(disp());
    check(32'(wrap));
    push("t4_wrap_after", 32'h0);      cyc(1); check(32'(wrap));

    // Pause with lap active: first ENTER drops lap, second clears.
    rel();
    cyc(27);
    push("t5_lap_on", 32'h1);
    push("t5_lap_value", 32'h3);
    press(ENTER_CODE_DEF);
    check(32'(lap_active));
    check(disp());
    rel();
    push("t5_pause_running", 32'h0);
    push("t5_pause_frozen", 32'h3);
    press(SPACE_CODE_DEF);
    check(32'(running));
    check(disp());
    rel();
    push("t5_lap_dropped", 32'h0);
    push("t5_live_kept", 32'h4);
    press(ENTER_CODE_DEF);
    check(32'(lap_active));
    check(disp());
    rel();
    push("t5_enter_clear", 32'h0);
    push("t5_enter_running", 32'h0);
    press(ENTER_CODE_DEF);
    check(disp());
    check(32'(running));

    // ESC on a tick edge, then async reset between clock edges.
    rel();
    press(SPACE_CODE_DEF);
    rel();
    cyc(12);
    push("t6_esc_tick_digits", 32'h0);
    push("t6_esc_tick_running", 32'h0);
    push("t6_esc_tick_wrap", 32'h0);
    press(ESC_CODE_DEF);
    check(disp());
    check(32'(running));
    check(32'(wrap));
    rel();
    press(SPACE_CODE_DEF);
    push("t6_counting", 32'h2);        cyc(25); check(disp());
    push("t6_async_digits", 32'h0);
    push("t6_async_running", 32'h0);
    #2;
    reset    = 1'b1;
    Released = 1'b1;
    #1;
    check(disp());
    check(32'(running));
    @(negedge clk_100MHz);
    reset = 1'b0;
    push("t6_idle_digits", 32'h0);
    push("t6_idle_running", 32'h0);
    cyc(30);
    check(disp());
    check(32'(running));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
